// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam int MOVE_TICKS_DEF     = 50000;
  localparam int DOOR_TICKS_DEF     = 100000;
  localparam int MOVE_TICKS_SIM_DEF = 4;
  localparam int DOOR_TICKS_SIM_DEF = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Call-button and car-status bundle between the panel side (master) and the controller (slave).
// ELEVATOR_DOOR_HOLD_EN adds the door_hold button.
interface elevator_ctrl_if #(
  parameter int FLOORS = 8
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] call_req;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic              door_hold;
`endif
  logic [FW-1:0]     floor;
  logic              move_up;
  logic              move_down;
  logic              door_open;
  logic [FLOORS-1:0] pending;

`ifdef ELEVATOR_DOOR_HOLD_EN
  modport master (
    output call_req, door_hold,
    input  floor, move_up, move_down, door_open, pending
  );
  modport slave (
    input  call_req, door_hold,
    output floor, move_up, move_down, door_open, pending
  );
`else
  modport master (
    output call_req,
    input  floor, move_up, move_down, door_open, pending
  );
  modport slave (
    input  call_req,
    output floor, move_up, move_down, door_open, pending
  );
`endif

endinterface

// File: rtl/elevator_ctrl_tick_timer.sv
// Up-counter shared by the travel and door phases; done flags the terminal count
// and the counter clears itself on the following edge.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] cnt_r;

  assign done = (cnt_r == terminal);

  // Count register: clear, hold at zero, wrap at terminal, otherwise increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr || hold || done) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-scheduled elevator car controller: latches calls, moves floor by floor, opens the door.
// Optional ELEVATOR_DOOR_HOLD_EN: door_hold keeps the door timer at zero while asserted.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter bit SIMULATION     = 1'b0,
  parameter int FLOORS         = 8,
  parameter int MOVE_TICKS     = MOVE_TICKS_DEF,
  parameter int DOOR_TICKS     = DOOR_TICKS_DEF,
  parameter int MOVE_TICKS_SIM = MOVE_TICKS_SIM_DEF,
  parameter int DOOR_TICKS_SIM = DOOR_TICKS_SIM_DEF
) (
  input logic            clk,
  input logic            rst_n,
  elevator_ctrl_if.slave bus
);

  localparam int MOVE_T = SIMULATION ? MOVE_TICKS_SIM : MOVE_TICKS;
  localparam int DOOR_T = SIMULATION ? DOOR_TICKS_SIM : DOOR_TICKS;
  localparam int TW     = $clog2(max_int(MOVE_T, DOOR_T) + 1);
  localparam int FW     = $clog2(FLOORS);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  state_t            state_r, state_s;
  logic [FW-1:0]     floor_r, floor_s;
  logic [FLOORS-1:0] pending_r, pending_s, merged_s;
  logic              dir_up_r, dir_up_s;
  logic              move_up_r, move_down_r, door_open_r;
  logic              above_s, below_s, restart_s;
  logic              tmr_clr_s, tmr_hold_s, tmr_done_s;
  logic [TW-1:0]     tmr_term_s;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      r = r | (v[i] & (i > int'(f)));
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      r = r | (v[i] & (i < int'(f)));
    end
    return r;
  endfunction

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign tmr_hold_s = (state_r == DOOR) & bus.door_hold;
`else
  assign tmr_hold_s = 1'b0;
`endif

  assign tmr_term_s = (state_r == DOOR) ? TW'(DOOR_T - 1) : TW'(MOVE_T - 1);

  tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_s),
    .hold     (tmr_hold_s),
    .terminal (tmr_term_s),
    .done     (tmr_done_s)
  );

  // Scheduler: next state, floor, direction, request vector and timer control.
  always_comb begin
    state_s   = state_r;
    floor_s   = floor_r;
    dir_up_s  = dir_up_r;
    tmr_clr_s = 1'b0;
    merged_s  = pending_r | bus.call_req;
    above_s   = any_above(pending_r, floor_r);
    below_s   = any_below(pending_r, floor_r);
    restart_s = 1'b0;

    case (state_r)
      IDLE: begin
        tmr_clr_s = 1'b1;
        if (pending_r[floor_r]) begin
          state_s = DOOR;
        end else if ((dir_up_r && above_s) || (!dir_up_r && !below_s && above_s)) begin
          state_s = MOVE_UP;
        end else if (below_s) begin
          state_s = MOVE_DOWN;
        end else begin
          state_s = IDLE;
        end
      end
      MOVE_UP: begin
        if (tmr_done_s) begin
          tmr_clr_s = 1'b1;
          floor_s   = (floor_r == TOP_FLOOR) ? floor_r : floor_r + FW'(1);
          // A call arriving on the same edge as the car still stops it here.
          if (merged_s[floor_s]) begin
            state_s = DOOR;
          end else if (any_above(merged_s, floor_s)) begin
            state_s = MOVE_UP;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = MOVE_UP;
        end
      end
      MOVE_DOWN: begin
        if (tmr_done_s) begin
          tmr_clr_s = 1'b1;
          floor_s   = (floor_r == '0) ? floor_r : floor_r - FW'(1);
          if (merged_s[floor_s]) begin
            state_s = DOOR;
          end else if (any_below(merged_s, floor_s)) begin
            state_s = MOVE_DOWN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = MOVE_DOWN;
        end
      end
      DOOR: begin
        restart_s = bus.call_req[floor_r] | tmr_hold_s;
        if (restart_s) begin
          tmr_clr_s = 1'b1;
          state_s   = DOOR;
        end else if (tmr_done_s) begin
          tmr_clr_s = 1'b1;
          if (dir_up_r && above_s) begin
            state_s = MOVE_UP;
          end else if (!dir_up_r && below_s) begin
            state_s = MOVE_DOWN;
          end else if (above_s) begin
            state_s = MOVE_UP;
          end else if (below_s) begin
            state_s = MOVE_DOWN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DOOR;
        end
      end
      default: begin
        state_s   = IDLE;
        tmr_clr_s = 1'b1;
      end
    endcase

    if (state_s == MOVE_UP) begin
      dir_up_s = 1'b1;
    end else if (state_s == MOVE_DOWN) begin
      dir_up_s = 1'b0;
    end else begin
      dir_up_s = dir_up_r;
    end

    pending_s = merged_s;
    if (state_r == DOOR) begin
      pending_s[floor_r] = 1'b0;
    end else if (state_s == DOOR) begin
      pending_s[floor_s] = 1'b0;
    end else begin
      pending_s = merged_s;
    end
  end

  // State, position, request and registered output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      floor_r     <= '0;
      pending_r   <= '0;
      dir_up_r    <= 1'b1;
      move_up_r   <= 1'b0;
      move_down_r <= 1'b0;
      door_open_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      floor_r     <= floor_s;
      pending_r   <= pending_s;
      dir_up_r    <= dir_up_s;
      move_up_r   <= (state_s == MOVE_UP);
      move_down_r <= (state_s == MOVE_DOWN);
      door_open_r <= (state_s == DOOR);
    end
  end

  assign bus.floor     = floor_r;
  assign bus.pending   = pending_r;
  assign bus.move_up   = move_up_r;
  assign bus.move_down = move_down_r;
  assign bus.door_open = door_open_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed table-driven bench for elevator_ctrl (SIMULATION=1, 8 floors), plus door-length sequence.
module tb_elevator_ctrl;

  logic clk;
  logic rst_n;

  elevator_ctrl_if #(.FLOORS(8)) bus ();

  elevator_ctrl #(
    .SIMULATION (1'b1),
    .FLOORS     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic [7:0] call;
    int         n;
    logic [2:0] floor;
    logic [2:0] mdd;   // {move_up, move_down, door_open}
    logic [7:0] pend;
  } vec_t;

  localparam logic [2:0] I = 3'b000;
  localparam logic [2:0] U = 3'b100;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] O = 3'b001;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic [7:0] c, input int n,
                              input logic [2:0] f, input logic [2:0] m, input logic [7:0] p);
    vec_t v;
    v.rst_n = r; v.call = c; v.n = n; v.floor = f; v.mdd = m; v.pend = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d t=%0t: got %0h expected %0h", name, idx, $time, got, exp);
    end
  endtask

  initial begin
    int len;
    int wait_cnt;

    rst_n = 1'b0;
    bus.call_req = 8'h00;
`ifdef ELEVATOR_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif

    // Reset, then one call to floor 3 from floor 0.
    add(1'b0, 8'h00, 2, 3'd0, I, 8'h00);
    add(1'b1, 8'h08, 1, 3'd0, I, 8'h08);
    add(1'b1, 8'h00, 4, 3'd0, U, 8'h08);
    add(1'b1, 8'h00, 4, 3'd1, U, 8'h08);
    add(1'b1, 8'h00, 4, 3'd2, U, 8'h08);
    add(1'b1, 8'h00, 6, 3'd3, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd3, I, 8'h00);
    // At 3 heading up, calls at 5 and 1: serve 5, then reverse to 1.
    add(1'b1, 8'h22, 1, 3'd3, I, 8'h22);
    add(1'b1, 8'h00, 4, 3'd3, U, 8'h22);
    add(1'b1, 8'h00, 4, 3'd4, U, 8'h22);
    add(1'b1, 8'h00, 6, 3'd5, O, 8'h02);
    add(1'b1, 8'h00, 4, 3'd5, D, 8'h02);
    add(1'b1, 8'h00, 4, 3'd4, D, 8'h02);
    add(1'b1, 8'h00, 4, 3'd3, D, 8'h02);
    add(1'b1, 8'h00, 4, 3'd2, D, 8'h02);
    add(1'b1, 8'h00, 6, 3'd1, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd1, I, 8'h00);
    // Heading down with nothing below: go up to 2, then call at the idle floor.
    add(1'b1, 8'h04, 1, 3'd1, I, 8'h04);
    add(1'b1, 8'h00, 4, 3'd1, U, 8'h04);
    add(1'b1, 8'h00, 6, 3'd2, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd2, I, 8'h00);
    add(1'b1, 8'h04, 1, 3'd2, I, 8'h04);
    add(1'b1, 8'h00, 6, 3'd2, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd2, I, 8'h00);
    // Door at 4 restarted by a call at 4 when the door count is 4.
    add(1'b1, 8'h10, 1, 3'd2, I, 8'h10);
    add(1'b1, 8'h00, 4, 3'd2, U, 8'h10);
    add(1'b1, 8'h00, 4, 3'd3, U, 8'h10);
    add(1'b1, 8'h00, 5, 3'd4, O, 8'h00);
    add(1'b1, 8'h10, 1, 3'd4, O, 8'h00);
    add(1'b1, 8'h00, 5, 3'd4, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd4, I, 8'h00);
    // Reset while moving at floor 5.
    add(1'b1, 8'h80, 1, 3'd4, I, 8'h80);
    add(1'b1, 8'h00, 4, 3'd4, U, 8'h80);
    add(1'b1, 8'h00, 1, 3'd5, U, 8'h80);
    add(1'b0, 8'h00, 1, 3'd0, I, 8'h00);
    add(1'b1, 8'h00, 2, 3'd0, I, 8'h00);
    // Call for floor 1 arriving on the same edge as the car.
    add(1'b1, 8'h04, 1, 3'd0, I, 8'h04);
    add(1'b1, 8'h00, 4, 3'd0, U, 8'h04);
    add(1'b1, 8'h02, 1, 3'd1, O, 8'h04);
    add(1'b1, 8'h00, 5, 3'd1, O, 8'h04);
    add(1'b1, 8'h00, 4, 3'd1, U, 8'h04);
    add(1'b1, 8'h00, 6, 3'd2, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd2, I, 8'h00);
    // Travel to the top floor, then all the way to the bottom.
    add(1'b1, 8'h80, 1, 3'd2, I, 8'h80);
    for (int f = 2; f <= 6; f++) add(1'b1, 8'h00, 4, 3'(f), U, 8'h80);
    add(1'b1, 8'h00, 6, 3'd7, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd7, I, 8'h00);
    add(1'b1, 8'h01, 1, 3'd7, I, 8'h01);
    for (int f = 7; f >= 1; f--) add(1'b1, 8'h00, 4, 3'(f), D, 8'h01);
    add(1'b1, 8'h00, 6, 3'd0, O, 8'h00);
    add(1'b1, 8'h00, 1, 3'd0, I, 8'h00);

    foreach (vecs[vi]) begin
      for (int k = 0; k < vecs[vi].n; k++) begin
        rst_n        = vecs[vi].rst_n;
        bus.call_req = vecs[vi].call;
        @(posedge clk);
        #1;
        check("floor", vi, 32'(bus.floor), 32'(vecs[vi].floor));
        check("motion", vi, 32'({bus.move_up, bus.move_down, bus.door_open}), 32'(vecs[vi].mdd));
        check("pending", vi, 32'(bus.pending), 32'(vecs[vi].pend));
      end
    end

    // Door interval at the idle floor, optionally stretched by door_hold.
    bus.call_req = 8'h01;
    @(posedge clk);
    #1;
    bus.call_req = 8'h00;
    wait_cnt = 0;
    while (!bus.door_open && wait_cnt < 20) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    check("door_latency", 0, 32'(wait_cnt), 32'd1);
    check("door_seen", 0, 32'(bus.door_open), 32'd1);
`ifdef ELEVATOR_DOOR_HOLD_EN
    bus.door_hold = 1'b1;
`endif
    len = 0;
    while (bus.door_open && len < 100) begin
      len++;
`ifdef ELEVATOR_DOOR_HOLD_EN
      if (len == 21) bus.door_hold = 1'b0;
`endif
      @(posedge clk);
      #1;
    end
`ifdef ELEVATOR_DOOR_HOLD_EN
    check("door_len", 0, 32'(len), 32'd26);
`else
    check("door_len", 0, 32'(len), 32'd6);
`endif
    check("door_pending", 0, 32'(bus.pending), 32'd0);
    check("door_floor", 0, 32'(bus.floor), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Elevator car controller for the elevator design. It latches hall and car call buttons into a pending-request vector and schedules car movement with a SCAN policy: it keeps moving in one direction while requests remain in that direction. It also sequences per-floor travel and door-open intervals with an internal tick timer. It sits directly downstream of the power-on reset generator and is clocked by the board clock; its outputs drive the floor display and the motor and door indicators.

## Interface
- SIMULATION, 1'b0: when 1, timers shrink to MOVE_TICKS_SIM / DOOR_TICKS_SIM.
- FLOORS, 8: number of floors; supported range 2..16.
- MOVE_TICKS, 50000: clock cycles to travel one floor.
- DOOR_TICKS, 100000: clock cycles the door stays open.
- MOVE_TICKS_SIM, 4 and DOOR_TICKS_SIM, 6: timer values used when SIMULATION=1.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- call_req  in  FLOORS  call buttons, one bit per floor; level or pulse, sampled every cycle.
- floor  out  $clog2(FLOORS)  current car floor.
- move_up  out  1  car travelling up.
- move_down  out  1  car travelling down.
- door_open  out  1  door open at `floor`.
- pending  out  FLOORS  latched unserved requests.

## Operation
- State machine: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Direction register `dir_up`: set on entry to MOVE_UP, cleared on entry to MOVE_DOWN.
- Latching: `pending |= call_req` every cycle. Exception: while in DOOR, `call_req[floor]` is not latched and instead restarts the door timer.
- `above` = any pending bit with index > floor. `below` = any pending bit with index < floor.
- Transitions from IDLE, in priority order:
  - pending[floor] -> DOOR.
  - (dir_up & above) | (!dir_up & !below & above) -> MOVE_UP.
  - below -> MOVE_DOWN.
  - otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Timer counts 0..MOVE_TICKS-1; on the terminal count, floor changes by ±1 and the timer clears.
  - On that same edge, if pending[new floor] -> DOOR.
  - Otherwise, if requests remain in the current direction, stay in the move state; if not -> IDLE.
- DOOR:
  - On entry, pending[floor] is cleared and the timer clears.
  - On the terminal count DOOR_TICKS-1, evaluate:
    - requests in the current direction -> continue in that direction;
    - else requests in the opposite direction -> reverse;
    - else -> IDLE.
- Floor limits: floor never goes below 0 or above FLOORS-1. A request is never pending beyond the limits, so the scheduler cannot command a move past them.
- Outputs are registered: move_up = (state==MOVE_UP), move_down = (state==MOVE_DOWN), door_open = (state==DOOR).

## Timing
- Reset, when rst_n=0 at a posedge: state IDLE, floor 0, pending 0, dir_up 1, timer 0, move_up 0, move_down 0, door_open 0.
- Reset mid-move or mid-door is applied at the next edge unconditionally.
- call_req to pending: 1 cycle.
- pending to state change out of IDLE: 1 further cycle.
- Each floor takes exactly MOVE_TICKS cycles in a move state.
- The door stays open exactly DOOR_TICKS cycles, measured from the last restart.
- Simultaneous events:
  - A call for the floor being arrived at on the same edge is served by that stop.
  - A call set and cleared on the same edge: the clear wins only for the current floor in DOOR; otherwise the set wins.
- Timer width is $clog2(max(MOVE_TICKS, DOOR_TICKS)+1) bits; it never wraps, since it clears at each terminal count.

## Configuration
- ELEVATOR_DOOR_HOLD_EN defined:
  - Adds input `door_hold` (1 bit), placed after call_req.
  - While in DOOR with door_hold=1, the timer is held at 0, so the door stays open.
  - The full DOOR_TICKS interval runs after door_hold is released.
- ELEVATOR_DOOR_HOLD_EN undefined: the port is absent and the door interval is fixed.

## Structure
- Package `elevator_pkg`: state enum (IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR=3), plus the default tick constants and SIM tick constants.
- Sub-module `tick_timer`:
  - inputs clk, rst_n, clr, hold, terminal value;
  - output `done` (terminal count reached);
  - shared by the move and door phases.
- The scheduler's above/below reduction logic stays inline.

## Test plan
- SIMULATION=1, FLOORS=8. After reset, pulse call_req[3] -> move_up for 12 cycles, floor steps 1,2,3, then door_open for 6 cycles, pending=0, then IDLE.
- Car at floor 3 moving up with requests at 5 and 1 -> stops at 5 first, then reverses and stops at 1; pending[5] clears before pending[1].
- Idle at floor 2, pulse call_req[2] -> door_open asserts 2 cycles later; floor stays at 2.
- During DOOR at floor 4, pulse call_req[4] at door timer count 4 -> door stays open 6 more cycles; pending[4] stays 0.
- Assert rst_n=0 for 1 cycle mid-move at floor 5 -> next edge: floor=0, all outputs 0, pending=0.
- With ELEVATOR_DOOR_HOLD_EN, hold door_hold=1 for 20 cycles in DOOR -> door_open stays high for 20+6 cycles.
